// File: rtl/rf_pkg.sv
// ============================================================================
// rf_pkg : shared constants and types for the scoreboarded register file
// Revision: 1.0
// ============================================================================
`default_nettype none

package rf_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;
endpackage

`default_nettype wire

// File: rtl/regfile_sb_bits.sv
// ============================================================================
// regfile_sb_bits : per-register busy scoreboard, set wins over clear
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_sb_bits
    import rf_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_i,
    input  logic [AW-1:0]    set_addr_i,
    input  logic             clr_i,
    input  logic [AW-1:0]    clr_addr_i,
    output logic [NREGS-1:0] busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Clear first so a same-cycle set (a newer producer) overrides it.
    always_comb begin
        busy_d = busy_q;
        if (clr_i && (clr_addr_i != '0)) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_i && (set_addr_i != '0)) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

`default_nettype wire

// File: rtl/regfile_mp_sb.sv
// ============================================================================
// regfile_mp_sb : multi-port register file with bypass and busy scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_mp_sb
    import rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int AW     = $clog2(NREGS),
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    parameter int RD_REG = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr,
    output logic                any_busy
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy;
    logic             wr_en;
    logic             set_same;

    assign wr_en    = we && (waddr != '0);
    assign set_same = sb_set && (sb_addr == waddr);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr] <= wdata;
        end
    end

    regfile_sb_bits #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_i      (sb_set),
        .set_addr_i (sb_addr),
        .clr_i      (wr_en),
        .clr_addr_i (waddr),
        .busy_o     (busy)
    );

    genvar k;
    generate
        for (k = 0; k < NRD; k++) begin : g_rd
            logic [AW-1:0]   ra;
            logic            hit;
            logic [XLEN-1:0] sel;

            assign ra  = raddr[k*AW +: AW];
            assign hit = (BYPASS != 0) && wr_en && (waddr == ra);
            assign sel = hit ? wdata : regs_q[ra];

            // A register being written this cycle is no longer pending, unless re-issued now.
            assign rbusy[k] = rst && busy[ra]
                              && !((BYPASS != 0) && we && (waddr == ra) && !set_same);

            if (RD_REG != 0) begin : g_rd_reg
                logic [XLEN-1:0] rd_q;
                always_ff @(posedge clk) begin
                    if (!rst) begin
                        rd_q <= '0;
                    end else begin
                        rd_q <= sel;
                    end
                end
                assign rdata[k*XLEN +: XLEN] = rst ? rd_q : '0;
            end else begin : g_rd_comb
                assign rdata[k*XLEN +: XLEN] = rst ? sel : '0;
            end
        end
    endgenerate

    assign any_busy = |rbusy;

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
// ============================================================================
// tb_regfile_mp_sb : directed bench over three bypass/read-mode variants
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mp_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic        sb_set;
    logic [4:0]  sb_addr;

    logic [63:0] rdata_a, rdata_b, rdata_c;
    logic [1:0]  rbusy_a, rbusy_b, rbusy_c;
    logic        any_a, any_b, any_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // a: bypass + comb read, b: no bypass + comb read, c: bypass + registered read
    regfile_mp_sb #(.BYPASS(1), .RD_REG(0)) u_a (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata_a), .rbusy(rbusy_a), .sb_set(sb_set), .sb_addr(sb_addr), .any_busy(any_a));
    regfile_mp_sb #(.BYPASS(0), .RD_REG(0)) u_b (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata_b), .rbusy(rbusy_b), .sb_set(sb_set), .sb_addr(sb_addr), .any_busy(any_b));
    regfile_mp_sb #(.BYPASS(1), .RD_REG(1)) u_c (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata_c), .rbusy(rbusy_c), .sb_set(sb_set), .sb_addr(sb_addr), .any_busy(any_c));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; sb_set = 1'b0;
    endtask

    initial begin
        rst = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD;
        raddr = {5'd5, 5'd5}; sb_set = 1'b1; sb_addr = 5'd5;

        // Reset held two cycles with a write and a set attempted
        tick();
        #1;
        chk("rst_rdata_a", rdata_a, 64'h0);
        chk("rst_rbusy_a", {62'h0, rbusy_a}, 64'h0);
        chk("rst_rdata_c", rdata_c, 64'h0);
        tick();
        chk("rst_rbusy_c", {62'h0, rbusy_c}, 64'h0);
        rst = 1'b1; idle();
        #1;
        chk("rst_r5_a", rdata_a, 64'h0);
        chk("rst_r5_busy", {62'h0, rbusy_a}, 64'h0);
        tick();
        chk("rst_r5_c", rdata_c, 64'h0);

        // Register zero: write and busy set are ignored
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        sb_set = 1'b1; sb_addr = 5'd0; raddr = {5'd0, 5'd0};
        #1;
        chk("x0_same_a", rdata_a, 64'h0);
        tick();
        idle();
        #1;
        chk("x0_rdata_a", rdata_a, 64'h0);
        chk("x0_rbusy_a", {62'h0, rbusy_a}, 64'h0);
        chk("x0_any_a", {63'h0, any_a}, 64'h0);
        chk("x0_rdata_c", rdata_c, 64'h0);

        // Write r7: no-bypass variant sees old value in the write cycle
        we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678; raddr = {5'd7, 5'd7};
        #1;
        chk("r7_same_b", rdata_b, 64'h0);
        chk("r7_same_a", rdata_a, 64'h1234_5678_1234_5678);
        tick();
        idle();
        #1;
        chk("r7_next_b", rdata_b, 64'h1234_5678_1234_5678);
        chk("r7_next_c", rdata_c, 64'h1234_5678_1234_5678);

        // Bypass on r3, both ports
        we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5_A5A5; raddr = {5'd3, 5'd3};
        #1;
        chk("byp_same_a", rdata_a, 64'hA5A5_A5A5_A5A5_A5A5);
        tick();
        idle();
        #1;
        chk("byp_reg_c", rdata_c, 64'hA5A5_A5A5_A5A5_A5A5);
        chk("byp_next_b", rdata_b, 64'hA5A5_A5A5_A5A5_A5A5);

        // Scoreboard set on r9, then writeback
        sb_set = 1'b1; sb_addr = 5'd9; raddr = {5'd0, 5'd9};
        #1;
        chk("sb_pre_a", {62'h0, rbusy_a}, 64'h0);
        tick();
        idle();
        #1;
        chk("sb_set_a", {62'h0, rbusy_a}, 64'h1);
        chk("sb_any_a", {63'h0, any_a}, 64'h1);
        chk("sb_set_b", {62'h0, rbusy_b}, 64'h1);
        we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0099;
        #1;
        chk("sb_wb_byp_a", {62'h0, rbusy_a}, 64'h0);
        chk("sb_wb_nobyp_b", {62'h0, rbusy_b}, 64'h1);
        chk("sb_wb_data_a", rdata_a, 64'h0000_0000_0000_0099);
        tick();
        idle();
        #1;
        chk("sb_clr_a", {62'h0, rbusy_a}, 64'h0);
        chk("sb_clr_b", {62'h0, rbusy_b}, 64'h0);
        chk("sb_clr_any_b", {63'h0, any_b}, 64'h0);

        // Same-cycle set and clear on r9: set wins, data still written
        sb_set = 1'b1; sb_addr = 5'd9; raddr = {5'd9, 5'd9};
        tick();
        we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0AAA;
        #1;
        chk("sc_same_a", {62'h0, rbusy_a}, 64'h3);
        tick();
        idle();
        #1;
        chk("sc_busy_a", {62'h0, rbusy_a}, 64'h3);
        chk("sc_busy_c", {62'h0, rbusy_c}, 64'h3);
        chk("sc_data_b", rdata_b, 64'h0000_0AAA_0000_0AAA);

        // Mid-operation reset flushes scoreboard and registers
        we = 1'b1; waddr = 5'd4; wdata = 32'h44; sb_set = 1'b1; sb_addr = 5'd6;
        raddr = {5'd4, 5'd6};
        tick();
        we = 1'b0; sb_addr = 5'd4;
        tick();
        idle();
        #1;
        chk("mid_busy_pre", {62'h0, rbusy_a}, 64'h3);
        chk("mid_r4_pre", rdata_a, 64'h0000_0044_0000_0000);
        rst = 1'b0;
        #1;
        chk("mid_rst_rbusy", {62'h0, rbusy_a}, 64'h0);
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rbusy_a", {62'h0, rbusy_a}, 64'h0);
        chk("mid_any_a", {63'h0, any_a}, 64'h0);
        chk("mid_rdata_a", rdata_a, 64'h0);
        raddr = {5'd9, 5'd7};
        #1;
        chk("mid_r9_r7_b", rdata_b, 64'h0);
        chk("mid_any_c", {63'h0, any_c}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
